// File: rtl/program_counter.sv
// RV32I program counter: registered fetch address with prioritised
// hold / increment / absolute load / PC-relative branch selection.
module program_counter #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic        inc,
  input  logic        ALU_out,
  input  logic        Disable,
  input  logic [31:0] data,
  input  logic [31:0] imm_val,
  output logic [31:0] pc_val
);

  logic [31:0] pc;
  logic [31:0] pc_next;

  // Stall outranks every request; the +4 on load/branch skips past the target slot.
  always_comb begin
    pc_next = pc;
    if (Disable) begin
      pc_next = pc;
    end else if (load) begin
      pc_next = data + 32'd4;
    end else if (ALU_out) begin
      pc_next = pc + imm_val + 32'd4;
    end else if (inc) begin
      pc_next = pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pc <= RESET_VAL;
    end else begin
      pc <= pc_next;
    end
  end

  assign pc_val = pc;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed vectors push hand-computed
// expectations; an independent monitor pops and compares after each edge.
module tb_program_counter;

  logic        clk;
  logic        clr;
  logic        load;
  logic        inc;
  logic        ALU_out;
  logic        Disable;
  logic [31:0] data;
  logic [31:0] imm_val;
  logic [31:0] pc_val;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          num_checks;
  int          num_fails;

  program_counter #(.RESET_VAL(32'h0000_0000)) dut (
    .clk     (clk),
    .clr     (clr),
    .load    (load),
    .inc     (inc),
    .ALU_out (ALU_out),
    .Disable (Disable),
    .data    (data),
    .imm_val (imm_val),
    .pc_val  (pc_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one edge's inputs on the falling edge and queue the value pc_val must show after the next rising edge.
  task automatic applyStimulus(input string name, input logic c, input logic dis,
                               input logic ld, input logic in, input logic br,
                               input logic [31:0] d, input logic [31:0] imm,
                               input logic [31:0] expected);
    @(negedge clk);
    clr     = c;
    Disable = dis;
    load    = ld;
    inc     = in;
    ALU_out = br;
    data    = d;
    imm_val = imm;
    exp_q.push_back(expected);
    name_q.push_back(name);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] expected);
    num_checks++;
    if (pc_val !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: pc_val=%h expected=%h", name, pc_val, expected);
    end
  endtask

  // Monitor: every rising edge produces a new pc_val, so pop one expectation per edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        checkOutput(name_q.pop_front(), exp_q.pop_front());
      end
    end
  end

  initial begin
    int wait_cycles;
    num_checks = 0;
    num_fails  = 0;
    clr = 1'b0; Disable = 1'b0; load = 1'b0; inc = 1'b0; ALU_out = 1'b0;
    data = 32'h0; imm_val = 32'h0;

    //                name              clr dis ld  inc br  data          imm           expected
    applyStimulus("reset_a",          1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000);
    applyStimulus("reset_b",          1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000);
    applyStimulus("inc_1",            0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0000_0004);
    applyStimulus("inc_2",            0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0000_0008);
    applyStimulus("reset_mid",        1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000);
    applyStimulus("reset_with_inc",   1, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0000_0000);
    applyStimulus("load_20",          0, 0, 1, 0, 0, 32'd20,       32'h0,        32'd24);
    applyStimulus("load_inc_100",     0, 0, 1, 1, 0, 32'd100,      32'h0,        32'd104);
    applyStimulus("load_20_again",    0, 0, 1, 0, 0, 32'd20,       32'h0,        32'd24);
    applyStimulus("stall_1",          0, 1, 1, 1, 0, 32'h0,        32'h0,        32'd24);
    applyStimulus("stall_2",          0, 1, 1, 1, 0, 32'h0,        32'h0,        32'd24);
    applyStimulus("stall_3",          0, 1, 1, 1, 1, 32'h0,        32'd8,        32'd24);
    applyStimulus("stall_4",          0, 1, 1, 1, 0, 32'h0,        32'h0,        32'd24);
    applyStimulus("stall_release",    0, 0, 0, 1, 0, 32'h0,        32'h0,        32'd28);
    applyStimulus("idle_hold",        0, 0, 0, 0, 0, 32'h0,        32'h0,        32'd28);
    applyStimulus("reset_pre_br",     1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0000_0000);
    applyStimulus("branch_fwd_8",     0, 0, 0, 0, 1, 32'h0,        32'd8,        32'd12);
    applyStimulus("branch_back_16",   0, 0, 0, 0, 1, 32'h0,        32'hFFFF_FFF0, 32'h0000_0000);
    applyStimulus("branch_with_inc",  0, 0, 0, 1, 1, 32'h0,        32'd8,        32'd12);
    applyStimulus("load_beats_br",    0, 0, 1, 0, 1, 32'd40,       32'd100,      32'd44);
    applyStimulus("reset_beats_stall",1, 1, 1, 1, 1, 32'd40,       32'd100,      32'h0000_0000);
    applyStimulus("load_near_top",    0, 0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0,       32'hFFFF_FFFC);
    applyStimulus("inc_wrap",         0, 0, 0, 1, 0, 32'h0,        32'h0,        32'h0000_0000);
    applyStimulus("unaligned_load",   0, 0, 1, 0, 0, 32'h0000_0011, 32'h0,       32'h0000_0015);

    @(negedge clk);
    clr = 1'b0; Disable = 1'b0; load = 1'b0; inc = 1'b0; ALU_out = 1'b0;

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      num_checks++;
      num_fails++;
      $display("[TB] FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
